// File: rtl/pen_lift_ctrl.sv
// Pen lift controller: synchronized, debounced limit switch, move/settle FSM with timeout and fault handling.
// Optional soft-start duty ramp is enabled by defining PEN_SOFTSTART_EN.
module pen_lift_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd25000000,
  parameter logic [15:0] SETTLE_CYCLES   = 16'd50000,
  parameter logic [15:0] DUTY_RUN        = 16'd128,
  parameter logic [15:0] DUTY_START      = 16'd224,
  parameter logic [15:0] RAMP_STEP       = 16'd8,
  parameter logic [15:0] RAMP_PERIOD     = 16'd50000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_pen,
  output logic        cmd_ready,
  input  logic        clear_err,
  input  logic        limit_switch,
  input  logic        fault_n,
  output logic        motor_enable,
  output logic [15:0] motor_duty,
  output logic        motor_set_pen,
  output logic        pen_down,
  output logic        busy,
  output logic        done,
  output logic        err_fault,
  output logic        err_timeout
);

  typedef enum logic [2:0] {ST_IDLE, ST_MOVE, ST_SETTLE, ST_FAULT, ST_TIMEOUT} state_e;

  state_e      state_q, state_d;
  logic        lim_s1_q, lim_s2_q, flt_s1_q, flt_s2_q;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [16:0] deb_cnt_inc;
  logic        pen_down_q, pen_down_d;
  logic [31:0] st_cnt_q, st_cnt_d;
  logic [32:0] st_cnt_inc;
  logic        set_pen_q, set_pen_d;
  logic        done_q, done_d;
  logic        accept;

  // Synchronizers idle high: switch up, no fault.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      lim_s1_q <= 1'b1;
      lim_s2_q <= 1'b1;
      flt_s1_q <= 1'b1;
      flt_s2_q <= 1'b1;
    end else begin
      lim_s1_q <= limit_switch;
      lim_s2_q <= lim_s1_q;
      flt_s1_q <= fault_n;
      flt_s2_q <= flt_s1_q;
    end
  end

  assign deb_cnt_inc = {1'b0, deb_cnt_q} + 17'd1;

  always_comb begin
    pen_down_d = pen_down_q;
    deb_cnt_d  = '0;
    if (!lim_s2_q != pen_down_q) begin
      if (deb_cnt_inc >= {1'b0, DEBOUNCE_CYCLES}) pen_down_d = !lim_s2_q;
      else                                        deb_cnt_d  = deb_cnt_inc[15:0];
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      pen_down_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      pen_down_q <= pen_down_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign st_cnt_inc = {1'b0, st_cnt_q} + 33'd1;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      st_cnt_q  <= '0;
      set_pen_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_cnt_q  <= st_cnt_d;
      set_pen_q <= set_pen_d;
      done_q    <= done_d;
    end
  end

  // A synchronized fault overrides every other transition, including acceptance.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (!flt_s2_q) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            accept  = 1'b1;
            state_d = (cmd_pen == pen_down_q) ? ST_SETTLE : ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (pen_down_q == set_pen_q)                         state_d = ST_SETTLE;
          else if (st_cnt_inc >= {1'b0, TIMEOUT_CYCLES})       state_d = ST_TIMEOUT;
        end
        ST_SETTLE: begin
          if (st_cnt_inc >= {17'd0, SETTLE_CYCLES})            state_d = ST_IDLE;
        end
        ST_FAULT, ST_TIMEOUT: begin
          if (clear_err) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    set_pen_d = accept ? cmd_pen : set_pen_q;
    done_d    = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
    if (state_d != state_q)   st_cnt_d = '0;
    else if (&st_cnt_q)       st_cnt_d = st_cnt_q;
    else                      st_cnt_d = st_cnt_inc[31:0];
  end

  always_comb begin
    cmd_ready    = (state_q == ST_IDLE) && !reset && flt_s2_q;
    motor_enable = (state_q == ST_MOVE);
    busy         = (state_q != ST_IDLE);
    err_fault    = (state_q == ST_FAULT);
    err_timeout  = (state_q == ST_TIMEOUT);
  end

  assign motor_set_pen = set_pen_q;
  assign pen_down      = pen_down_q;
  assign done          = done_q;

`ifdef PEN_SOFTSTART_EN
  logic [15:0] duty_q, duty_d, ramp_cnt_q, ramp_cnt_d, duty_step;
  logic [16:0] ramp_inc;

  assign ramp_inc = {1'b0, ramp_cnt_q} + 17'd1;

  // Step toward DUTY_RUN from either side without overshooting it.
  always_comb begin
    duty_step = DUTY_RUN;
    if (duty_q > DUTY_RUN) begin
      if (duty_q - DUTY_RUN > RAMP_STEP) duty_step = duty_q - RAMP_STEP;
    end else if (duty_q < DUTY_RUN) begin
      if (DUTY_RUN - duty_q > RAMP_STEP) duty_step = duty_q + RAMP_STEP;
    end
  end

  always_comb begin
    duty_d     = DUTY_RUN;
    ramp_cnt_d = '0;
    if (state_d == ST_MOVE) begin
      if (state_q != ST_MOVE) begin
        duty_d = DUTY_START;
      end else if (ramp_inc >= {1'b0, RAMP_PERIOD}) begin
        duty_d = duty_step;
      end else begin
        duty_d     = duty_q;
        ramp_cnt_d = ramp_inc[15:0];
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      duty_q     <= DUTY_RUN;
      ramp_cnt_q <= '0;
    end else begin
      duty_q     <= duty_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  assign motor_duty = duty_q;
`else
  logic unused_ramp_params;
  assign unused_ramp_params = ^{DUTY_START, RAMP_STEP, RAMP_PERIOD};
  assign motor_duty = DUTY_RUN;
`endif

endmodule

// File: tb/tb_pen_lift_ctrl.sv
// Directed bench for pen_lift_ctrl; a second instance with a short timeout shares all inputs.
module tb_pen_lift_ctrl;

  logic        clk_50 = 1'b0;
  logic        reset, cmd_valid, cmd_pen, clear_err, limit_switch, fault_n;
  logic        cmd_ready, motor_enable, motor_set_pen, pen_down, busy, done, err_fault, err_timeout;
  logic [15:0] motor_duty;
  logic        t_cmd_ready, t_motor_enable, t_motor_set_pen, t_pen_down, t_busy, t_done;
  logic        t_err_fault, t_err_timeout;
  logic [15:0] t_motor_duty;

  int checks = 0;
  int errors = 0;

  always #10 clk_50 = ~clk_50;

  pen_lift_ctrl #(
    .DEBOUNCE_CYCLES(16'd8), .TIMEOUT_CYCLES(32'd4000), .SETTLE_CYCLES(16'd20),
    .DUTY_RUN(16'd128), .DUTY_START(16'd224), .RAMP_STEP(16'd8), .RAMP_PERIOD(16'd4)
  ) dut (
    .clk_50(clk_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_pen(cmd_pen),
    .cmd_ready(cmd_ready), .clear_err(clear_err), .limit_switch(limit_switch),
    .fault_n(fault_n), .motor_enable(motor_enable), .motor_duty(motor_duty),
    .motor_set_pen(motor_set_pen), .pen_down(pen_down), .busy(busy), .done(done),
    .err_fault(err_fault), .err_timeout(err_timeout)
  );

  pen_lift_ctrl #(
    .DEBOUNCE_CYCLES(16'd8), .TIMEOUT_CYCLES(32'd1000), .SETTLE_CYCLES(16'd20),
    .DUTY_RUN(16'd128), .DUTY_START(16'd224), .RAMP_STEP(16'd8), .RAMP_PERIOD(16'd4)
  ) dut_t (
    .clk_50(clk_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_pen(cmd_pen),
    .cmd_ready(t_cmd_ready), .clear_err(clear_err), .limit_switch(limit_switch),
    .fault_n(fault_n), .motor_enable(t_motor_enable), .motor_duty(t_motor_duty),
    .motor_set_pen(t_motor_set_pen), .pen_down(t_pen_down), .busy(t_busy), .done(t_done),
    .err_fault(t_err_fault), .err_timeout(t_err_timeout)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_pen = 1'b0; clear_err = 1'b0;
    limit_switch = 1'b1; fault_n = 1'b1;
    tick(3);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_motor_enable", motor_enable, 0);
    chk("rst_motor_duty", motor_duty, 128);
    chk("rst_set_pen", motor_set_pen, 0);
    chk("rst_done", done, 0);
    chk("rst_pen_down", pen_down, 0);
    chk("rst_errs", {err_fault, err_timeout}, 0);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Pen down move; switch falls ~1000 cycles after acceptance.
    cmd_valid = 1'b1; cmd_pen = 1'b1;
    tick(1);
    chk("move_enable", motor_enable, 1);
    chk("move_busy", busy, 1);
    chk("move_cmd_ready", cmd_ready, 0);
    chk("move_set_pen", motor_set_pen, 1);
    chk("move_duty", motor_duty, 128);
    cmd_pen = 1'b0;
    tick(1);
    cmd_valid = 1'b0;
    chk("busy_cmd_ignored_pen", motor_set_pen, 1);
    chk("busy_cmd_ignored_enable", motor_enable, 1);
    tick(998);
    limit_switch = 1'b0;
    tick(9);
    chk("debounce_not_yet", pen_down, 0);
    tick(1);
    chk("debounce_rise", pen_down, 1);
    chk("arrive_still_move", motor_enable, 1);
    tick(1);
    chk("settle_enable", motor_enable, 0);
    chk("settle_busy", busy, 1);
    tick(19);
    chk("settle_no_done_yet", done, 0);
    tick(1);
    chk("done_pulse", done, 1);
    chk("done_idle", busy, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    tick(1);
    chk("done_one_cycle", done, 0);

    // Command equal to current position: straight to SETTLE.
    cmd_valid = 1'b1; cmd_pen = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    chk("same_pos_enable", motor_enable, 0);
    chk("same_pos_busy", busy, 1);
    tick(19);
    chk("same_pos_no_done", done, 0);
    chk("same_pos_enable_hold", motor_enable, 0);
    tick(1);
    chk("same_pos_done", done, 1);

    // Timeout on the short-timeout instance, switch held up.
    reset = 1'b1; limit_switch = 1'b1;
    tick(2);
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_pen = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(999);
    chk("pre_timeout_enable", t_motor_enable, 1);
    chk("pre_timeout_flag", t_err_timeout, 0);
    tick(1);
    chk("timeout_flag", t_err_timeout, 1);
    chk("timeout_enable", t_motor_enable, 0);
    chk("long_to_still_move", motor_enable, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("timeout_cleared", t_err_timeout, 0);
    chk("timeout_cleared_ready", t_cmd_ready, 1);
    chk("clear_ignored_in_move", motor_enable, 1);

    // Fault coincident with a command offer.
    fault_n = 1'b0;
    tick(2);
    cmd_valid = 1'b1; cmd_pen = 1'b0;
    tick(1);
    cmd_valid = 1'b0;
    chk("fault_flag", t_err_fault, 1);
    chk("fault_cmd_rejected", t_motor_set_pen, 1);
    chk("fault_from_move", err_fault, 1);
    chk("fault_stops_motor", motor_enable, 0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("fault_clear_blocked", t_err_fault, 1);
    fault_n = 1'b1;
    tick(2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("fault_cleared", t_err_fault, 0);
    chk("fault_cleared_ready", t_cmd_ready, 1);
    chk("fault_cleared_main", busy, 0);

    // Debounce glitch rejection.
    limit_switch = 1'b0;
    tick(3);
    limit_switch = 1'b1;
    tick(15);
    chk("glitch3_pen_down", pen_down, 0);
    limit_switch = 1'b0;
    tick(9);
    chk("real_fall_not_yet", pen_down, 0);
    tick(1);
    chk("real_fall", pen_down, 1);
    limit_switch = 1'b1;
    tick(7);
    limit_switch = 1'b0;
    tick(15);
    chk("glitch7_pen_down", pen_down, 1);

    // Duty during a move, then reset mid-move.
    cmd_valid = 1'b1; cmd_pen = 1'b0;
    tick(1);
    cmd_valid = 1'b0;
    chk("move2_enable", motor_enable, 1);
`ifdef PEN_SOFTSTART_EN
    for (int k = 0; k < 12; k++) begin
      chk("ramp_duty", motor_duty, 224 - 8 * k);
      tick(4);
    end
    chk("ramp_end", motor_duty, 128);
    tick(8);
    chk("ramp_hold", motor_duty, 128);
`else
    tick(10);
    chk("duty_const", motor_duty, 128);
`endif
    reset = 1'b1;
    tick(1);
    chk("reset_stops_motor", motor_enable, 0);
    chk("reset_duty", motor_duty, 128);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
